// File: rtl/ctrl_decode_stage_pkg.sv
// Shared types for the RV32I decode/control stage: opcodes, control bus layouts and sizes.
package ctrl_decode_stage_pkg;

    localparam int NB_WORD     = 32;
    localparam int NB_REG_ADDR = 5;
    localparam int NUM_REGS    = 2 ** NB_REG_ADDR;

    typedef enum logic [6:0] {
        OP_LUI    = 7'b0110111,
        OP_AUIPC  = 7'b0010111,
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_IMM    = 7'b0010011,
        OP_R_R    = 7'b0110011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_t;

    typedef struct packed {
        logic                   alu_src1;
        logic                   alu_src2;
        logic [2:0]             alu_op;
        logic                   arith_logic;
        logic                   dmem_rd;
        logic                   dmem_wr;
        logic [2:0]             ld_st_funct3;
        logic                   rf_wr;
        logic                   wb_to_rf;
        logic [NB_REG_ADDR-1:0] rd;
    } control_bus_t;

    typedef struct packed {
        control_bus_t           base;
        logic [NB_REG_ADDR-1:0] rs1;
        logic [NB_REG_ADDR-1:0] rs2;
        logic                   branch;
        logic                   jump;
        logic                   illegal;
    } ctrl_bus_ext_t;

endpackage

// File: rtl/ctrl_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage; signal names are from the stage's view.
// Both sides are valid/ready: a transfer happens on a rising clock edge where valid and ready are both high.
interface ctrl_decode_stage_if
    import ctrl_decode_stage_pkg::*;
();
    logic               i_valid;
    logic [NB_WORD-1:0] i_instruction;
    logic               o_ready;
    logic               o_valid;
    logic               i_ready;
    ctrl_bus_ext_t      o_control_bus;

    modport slave (
        input  i_valid, i_instruction, i_ready,
        output o_ready, o_valid, o_control_bus
    );

    modport master (
        output i_valid, i_instruction, i_ready,
        input  o_ready, o_valid, o_control_bus
    );
endinterface

// File: rtl/ctrl_decoder.sv
// Combinational RV32I decoder producing the extended control bus and source-register usage.
// BRANCH/JAL/JALR decode only when RISCV_CTRL_BRANCH_EN is defined; otherwise they are illegal.
module ctrl_decoder
    import ctrl_decode_stage_pkg::*;
(
    input  logic [NB_WORD-1:0] i_instruction,
    output ctrl_bus_ext_t      o_control,
    output logic               o_rs1_used,
    output logic               o_rs2_used
);

    opcode_t                w_opcode;
    logic [2:0]             w_funct3;
    logic                   w_funct7_any;
    logic [NB_REG_ADDR-1:0] w_rd;
    logic [NB_REG_ADDR-1:0] w_rs1;
    logic [NB_REG_ADDR-1:0] w_rs2;

    assign w_opcode     = opcode_t'(i_instruction[6:0]);
    assign w_rd         = i_instruction[11:7];
    assign w_funct3     = i_instruction[14:12];
    assign w_rs1        = i_instruction[19:15];
    assign w_rs2        = i_instruction[24:20];
    assign w_funct7_any = |i_instruction[31:25];

    always_comb begin
        o_control  = '0;
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
        case (w_opcode)
            OP_LUI, OP_AUIPC: begin
                o_control.base.alu_src1 = 1'b1;
                o_control.base.alu_src2 = 1'b1;
                o_control.base.rf_wr    = 1'b1;
            end
            OP_LOAD: begin
                o_control.base.alu_src2     = 1'b1;
                o_control.base.dmem_rd      = 1'b1;
                o_control.base.rf_wr        = 1'b1;
                o_control.base.wb_to_rf     = 1'b1;
                o_control.base.ld_st_funct3 = w_funct3;
                o_rs1_used                  = 1'b1;
            end
            OP_STORE: begin
                o_control.base.alu_src2 = 1'b1;
                o_control.base.dmem_wr  = 1'b1;
                o_rs1_used              = 1'b1;
                o_rs2_used              = 1'b1;
            end
            OP_IMM: begin
                o_control.base.alu_src2    = 1'b1;
                o_control.base.alu_op      = w_funct3;
                o_control.base.arith_logic = w_funct7_any;
                o_control.base.rf_wr       = 1'b1;
                o_rs1_used                 = 1'b1;
            end
            OP_R_R: begin
                o_control.base.alu_op      = w_funct3;
                o_control.base.arith_logic = w_funct7_any;
                o_control.base.rf_wr       = 1'b1;
                o_rs1_used                 = 1'b1;
                o_rs2_used                 = 1'b1;
            end
`ifdef RISCV_CTRL_BRANCH_EN
            OP_BRANCH: begin
                o_control.branch      = 1'b1;
                o_control.base.alu_op = w_funct3;
                o_rs1_used            = 1'b1;
                o_rs2_used            = 1'b1;
            end
            OP_JAL: begin
                o_control.jump          = 1'b1;
                o_control.base.alu_src1 = 1'b1;
                o_control.base.alu_src2 = 1'b1;
                o_control.base.rf_wr    = 1'b1;
            end
            OP_JALR: begin
                o_control.jump          = 1'b1;
                o_control.base.alu_src2 = 1'b1;
                o_control.base.rf_wr    = 1'b1;
                o_rs1_used              = 1'b1;
            end
`endif
            default: o_control.illegal = 1'b1;
        endcase

        // Illegal words keep every field zero; stores carry rs2 in the rd slot for the data path.
        if (!o_control.illegal) begin
            o_control.rs1     = w_rs1;
            o_control.rs2     = w_rs2;
            o_control.base.rd = (w_opcode == OP_STORE) ? w_rs2 : w_rd;
        end
    end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Registered decode/control stage with load scoreboard, load cap and hazard-stall counter.
// Optional BRANCH/JAL/JALR decoding is enabled by defining RISCV_CTRL_BRANCH_EN.
module ctrl_decode_stage
    import ctrl_decode_stage_pkg::*;
#(
    parameter  int MAX_LOADS = 2,
    parameter  int NB_STALL  = 16,
    localparam int NB_PEND   = $clog2(MAX_LOADS + 1)
) (
    input  logic                   i_clock,
    input  logic                   i_reset_n,
    ctrl_decode_stage_if.slave     io_bus,
    input  logic                   i_flush,
    input  logic                   i_wb_valid,
    input  logic [NB_REG_ADDR-1:0] i_wb_rd,
    output logic [NB_PEND-1:0]     o_pending_loads,
    output logic [NB_STALL-1:0]    o_stall_cycles
);

    localparam logic [NB_PEND-1:0] LOAD_CAP = NB_PEND'(MAX_LOADS);

    ctrl_bus_ext_t         w_dec;
    logic                  w_rs1_used;
    logic                  w_rs2_used;
    logic                  w_is_load;
    logic                  w_hazard;
    logic                  w_cap_stall;
    logic                  w_ready;
    logic                  w_accept;
    logic                  w_load_inc;
    logic                  w_load_dec;
    logic [NUM_REGS-1:0]   w_pending_nxt;

    logic                  r_valid;
    ctrl_bus_ext_t         r_control;
    logic [NUM_REGS-1:0]   r_pending;
    logic [NB_PEND-1:0]    r_load_cnt;
    logic [NB_STALL-1:0]   r_stall_cnt;

    ctrl_decoder u_decoder (
        .i_instruction (io_bus.i_instruction),
        .o_control     (w_dec),
        .o_rs1_used    (w_rs1_used),
        .o_rs2_used    (w_rs2_used)
    );

    // The hazard looks only at the registered scoreboard: a writeback frees its register next cycle.
    assign w_is_load   = w_dec.base.dmem_rd;
    assign w_hazard    = io_bus.i_valid &
                         ((w_rs1_used & r_pending[w_dec.rs1]) | (w_rs2_used & r_pending[w_dec.rs2]));
    assign w_cap_stall = io_bus.i_valid & w_is_load & (r_load_cnt == LOAD_CAP);
    assign w_ready     = (~r_valid | io_bus.i_ready) & ~w_hazard & ~w_cap_stall & ~i_flush;
    assign w_accept    = io_bus.i_valid & w_ready;
    assign w_load_inc  = w_accept & w_is_load;
    assign w_load_dec  = i_wb_valid & (r_load_cnt != '0);

    always_comb begin
        w_pending_nxt = r_pending;
        if (i_wb_valid) begin
            w_pending_nxt[i_wb_rd] = 1'b0;
        end
        if (w_load_inc) begin
            w_pending_nxt[w_dec.base.rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_valid   <= 1'b0;
            r_control <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid   <= 1'b1;
            r_control <= w_dec;
        end else if (io_bus.i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Flush leaves the scoreboard and load count alone: issued loads still write back.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pending  <= '0;
            r_load_cnt <= '0;
        end else begin
            r_pending <= w_pending_nxt;
            if (w_load_inc && !w_load_dec) begin
                r_load_cnt <= r_load_cnt + 1'b1;
            end else if (!w_load_inc && w_load_dec) begin
                r_load_cnt <= r_load_cnt - 1'b1;
            end
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_stall_cnt <= '0;
        end else if ((w_hazard || w_cap_stall) && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign io_bus.o_ready       = w_ready;
    assign io_bus.o_valid       = r_valid;
    assign io_bus.o_control_bus = r_control;
    assign o_pending_loads      = r_load_cnt;
    assign o_stall_cycles       = r_stall_cnt;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Self-checking bench for ctrl_decode_stage: directed scenarios plus random traffic against a behavioural model.
// Honours RISCV_CTRL_BRANCH_EN for the expected JAL/JALR/BRANCH decode.
module tb_ctrl_decode_stage;
    import ctrl_decode_stage_pkg::*;

    localparam int MAX_LOADS = 2;
    localparam int NB_STALL  = 10;
    localparam int NB_PEND   = $clog2(MAX_LOADS + 1);
    localparam int STALL_MAX = (1 << NB_STALL) - 1;
    localparam int BW        = $bits(ctrl_bus_ext_t);

    localparam logic [6:0] C_LOAD  = 7'b0000011;
    localparam logic [6:0] C_STORE = 7'b0100011;
    localparam logic [6:0] C_R_R   = 7'b0110011;

    // ---------------- clock / reset ----------------
    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   flush;
    logic                   wb_valid;
    logic [NB_REG_ADDR-1:0] wb_rd;
    logic [NB_PEND-1:0]     pending_loads;
    logic [NB_STALL-1:0]    stall_cycles;

    always #5 clk = ~clk;

    ctrl_decode_stage_if u_if ();

    ctrl_decode_stage #(
        .MAX_LOADS (MAX_LOADS),
        .NB_STALL  (NB_STALL)
    ) u_dut (
        .i_clock         (clk),
        .i_reset_n       (rst_n),
        .io_bus          (u_if),
        .i_flush         (flush),
        .i_wb_valid      (wb_valid),
        .i_wb_rd         (wb_rd),
        .o_pending_loads (pending_loads),
        .o_stall_cycles  (stall_cycles)
    );

    // ---------------- model state / scoreboard ----------------
    logic [BW-1:0] exp_q[$];
    bit            pend[NUM_REGS];
    int            loads_m;
    int            stall_m;
    bit            last_acc;
    int            n_checks = 0;
    int            n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decode straight from the opcode table; rd/rs fields are filled only for recognised opcodes.
    function automatic ctrl_bus_ext_t model_decode(input logic [31:0] ins, output bit u1, output bit u2);
        ctrl_bus_ext_t c;
        bit            legal;
        logic [2:0]    f3;
        logic          ar;
        c = '0; u1 = 0; u2 = 0; legal = 1;
        f3 = ins[14:12];
        ar = (ins[31:25] != 7'd0);
        case (ins[6:0])
            7'b0110111, 7'b0010111: begin
                c.base.alu_src1 = 1; c.base.alu_src2 = 1; c.base.rf_wr = 1;
            end
            7'b0000011: begin
                c.base.alu_src2 = 1; c.base.dmem_rd = 1; c.base.rf_wr = 1;
                c.base.wb_to_rf = 1; c.base.ld_st_funct3 = f3; u1 = 1;
            end
            7'b0100011: begin
                c.base.alu_src2 = 1; c.base.dmem_wr = 1; u1 = 1; u2 = 1;
            end
            7'b0010011: begin
                c.base.alu_src2 = 1; c.base.alu_op = f3; c.base.arith_logic = ar; c.base.rf_wr = 1; u1 = 1;
            end
            7'b0110011: begin
                c.base.alu_op = f3; c.base.arith_logic = ar; c.base.rf_wr = 1; u1 = 1; u2 = 1;
            end
`ifdef RISCV_CTRL_BRANCH_EN
            7'b1100011: begin
                c.branch = 1; c.base.alu_op = f3; u1 = 1; u2 = 1;
            end
            7'b1101111: begin
                c.jump = 1; c.base.alu_src1 = 1; c.base.alu_src2 = 1; c.base.rf_wr = 1;
            end
            7'b1100111: begin
                c.jump = 1; c.base.alu_src2 = 1; c.base.rf_wr = 1; u1 = 1;
            end
`endif
            default: legal = 0;
        endcase
        if (legal) begin
            c.rs1     = ins[19:15];
            c.rs2     = ins[24:20];
            c.base.rd = (ins[6:0] == C_STORE) ? ins[24:20] : ins[11:7];
        end else begin
            c.illegal = 1;
        end
        return c;
    endfunction

    // One clock: compare at the falling edge, advance the model, return just after the rising edge.
    task automatic cycle();
        ctrl_bus_ext_t d;
        bit            u1, u2, haz, cap, rdy, acc, ld;
        logic [31:0]   ins;
        @(negedge clk);
        ins = u_if.i_instruction;
        d   = model_decode(ins, u1, u2);
        ld  = (ins[6:0] == C_LOAD);
        haz = u_if.i_valid && ((u1 && pend[ins[19:15]]) || (u2 && pend[ins[24:20]]));
        cap = u_if.i_valid && ld && (loads_m == MAX_LOADS);
        rdy = (exp_q.size() == 0 || u_if.i_ready) && !haz && !cap && !flush;
        acc = u_if.i_valid && rdy;

        check("o_ready", 64'(u_if.o_ready), 64'(rdy));
        check("o_valid", 64'(u_if.o_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) check("o_control_bus", 64'(u_if.o_control_bus), 64'(exp_q[0]));
        check("o_pending_loads", 64'(pending_loads), 64'(loads_m));
        check("o_stall_cycles", 64'(stall_cycles), 64'(stall_m));

        if (flush) begin
            exp_q.delete();
        end else begin
            if (exp_q.size() != 0 && u_if.i_ready) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(BW'(d));
        end
        if (wb_valid) pend[wb_rd] = 0;
        if (acc && ld && ins[11:7] != 5'd0) pend[ins[11:7]] = 1;
        loads_m = loads_m + ((acc && ld) ? 1 : 0) - ((wb_valid && loads_m != 0) ? 1 : 0);
        if (u_if.i_valid && (haz || cap) && stall_m < STALL_MAX) stall_m++;
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [31:0] ins);
        u_if.i_valid       = v;
        u_if.i_instruction = ins;
    endtask

    task automatic set_wb(input logic v, input int rd);
        wb_valid = v;
        wb_rd    = NB_REG_ADDR'(rd);
    endtask

    task automatic model_reset();
        exp_q.delete();
        foreach (pend[i]) pend[i] = 0;
        loads_m = 0;
        stall_m = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 32'h0);
        u_if.i_ready = 1'b1;
        flush = 1'b0;
        set_wb(0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_r(input int rs2, input int rs1, input int rd);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), C_R_R};
    endfunction

    function automatic logic [31:0] enc_lw(input int rs1, input int rd);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), C_LOAD};
    endfunction

    function automatic logic [31:0] enc_sw(input int rs2, input int rs1);
        return {7'd0, 5'(rs2), 5'(rs1), 3'b010, 5'd0, C_STORE};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops[10] = '{7'b0110111, 7'b0010111, 7'b0000011, 7'b0100011, 7'b0010011,
                                 7'b0110011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b1111111};
        logic [31:0] ins;
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 9)];
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        return ins;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        ctrl_bus_ext_t jal_exp;
        do_reset();
        check("reset_o_valid", 64'(u_if.o_valid), 64'd0);
        check("reset_bus", 64'(u_if.o_control_bus), 64'd0);
        check("reset_pending", 64'(pending_loads), 64'd0);
        check("reset_stall", 64'(stall_cycles), 64'd0);

        // ADD x3,x1,x2 appears one cycle after acceptance
        drive(1, enc_r(2, 1, 3));
        cycle();
        check("add_valid", 64'(u_if.o_valid), 64'd1);
        check("add_rf_wr", 64'(u_if.o_control_bus.base.rf_wr), 64'd1);
        check("add_rd", 64'(u_if.o_control_bus.base.rd), 64'd3);
        check("add_alu_op", 64'(u_if.o_control_bus.base.alu_op), 64'd0);
        check("add_illegal", 64'(u_if.o_control_bus.illegal), 64'd0);
        drive(0, 32'h0);
        cycle();

        // LW x5 then dependent ADD x6,x5,x1
        drive(1, enc_lw(1, 5));
        cycle();
        drive(1, enc_r(1, 5, 6));
        repeat (3) cycle();
        check("raw_stall_cnt", 64'(stall_cycles), 64'd3);
        check("raw_ready_low", 64'(u_if.o_ready), 64'd0);
        set_wb(1, 5);
        cycle();
        set_wb(0, 0);
        #1;
        check("raw_ready_after_wb", 64'(u_if.o_ready), 64'd1);
        cycle();
        drive(0, 32'h0);
        cycle();

        // load cap: third outstanding load waits for a writeback
        drive(1, enc_lw(1, 8));
        cycle();
        drive(1, enc_lw(1, 9));
        cycle();
        drive(1, enc_lw(1, 10));
        cycle();
        check("cap_pending", 64'(pending_loads), 64'd2);
        check("cap_ready_low", 64'(u_if.o_ready), 64'd0);
        set_wb(1, 8);
        cycle();
        set_wb(0, 0);
        #1;
        check("cap_pending_after_wb", 64'(pending_loads), 64'd1);
        check("cap_ready_after_wb", 64'(u_if.o_ready), 64'd1);
        cycle();
        drive(0, 32'h0);
        set_wb(1, 9);
        cycle();
        set_wb(1, 10);
        cycle();
        set_wb(0, 0);

        // same-cycle set/clear of x7, then LW x0
        drive(1, enc_lw(1, 11));
        cycle();
        drive(1, enc_lw(1, 7));
        set_wb(1, 7);
        cycle();
        set_wb(0, 0);
        drive(1, enc_r(0, 7, 12));
        #1;
        check("setclr_pending", 64'(pending_loads), 64'd1);
        check("setclr_bit7_stall", 64'(u_if.o_ready), 64'd0);
        cycle();
        drive(1, enc_lw(1, 0));
        cycle();
        check("lw_x0_pending", 64'(pending_loads), 64'd2);
        drive(0, 32'h0);
        set_wb(1, 7);
        cycle();
        set_wb(1, 11);
        cycle();
        set_wb(0, 0);

        // held SW under backpressure, then flush with a load outstanding
        drive(1, enc_lw(1, 13));
        cycle();
        drive(0, 32'h0);
        cycle();
        u_if.i_ready = 1'b0;
        drive(1, enc_sw(2, 1));
        cycle();
        drive(0, 32'h0);
        repeat (3) cycle();
        check("sw_held_valid", 64'(u_if.o_valid), 64'd1);
        check("sw_dmem_wr", 64'(u_if.o_control_bus.base.dmem_wr), 64'd1);
        check("sw_rd_is_rs2", 64'(u_if.o_control_bus.base.rd), 64'd2);
        flush = 1'b1;
        drive(1, enc_r(2, 1, 4));
        cycle();
        flush = 1'b0;
        drive(0, 32'h0);
        check("flush_valid", 64'(u_if.o_valid), 64'd0);
        check("flush_pending_kept", 64'(pending_loads), 64'd1);
        u_if.i_ready = 1'b1;
        set_wb(1, 13);
        cycle();
        set_wb(0, 0);

        // JAL x1
        drive(1, {20'h12345, 5'd1, 7'b1101111});
        cycle();
        jal_exp = '0;
`ifdef RISCV_CTRL_BRANCH_EN
        check("jal_jump", 64'(u_if.o_control_bus.jump), 64'd1);
        check("jal_rf_wr", 64'(u_if.o_control_bus.base.rf_wr), 64'd1);
        check("jal_illegal", 64'(u_if.o_control_bus.illegal), 64'd0);
`else
        jal_exp.illegal = 1'b1;
        check("jal_illegal_bus", 64'(u_if.o_control_bus), 64'(jal_exp));
`endif
        drive(0, 32'h0);
        cycle();

        // reset while an instruction is held
        u_if.i_ready = 1'b0;
        drive(1, enc_r(2, 1, 3));
        cycle();
        drive(0, 32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", 64'(u_if.o_valid), 64'd0);
        do_reset();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            if (!u_if.i_valid || last_acc || flush) begin
                drive(1'($urandom_range(0, 3) != 0), rand_instr());
            end
            u_if.i_ready = 1'($urandom_range(0, 3) != 0);
            flush        = 1'($urandom_range(0, 31) == 0);
            set_wb(1'($urandom_range(0, 3) == 0), $urandom_range(0, 7));
            cycle();
        end

        // stall-counter saturation
        do_reset();
        drive(1, enc_lw(1, 5));
        cycle();
        drive(1, enc_r(1, 5, 6));
        repeat (STALL_MAX + 5) cycle();
        check("stall_saturated", 64'(stall_cycles), 64'(STALL_MAX));
        set_wb(1, 5);
        cycle();
        set_wb(0, 0);
        cycle();
        drive(0, 32'h0);
        cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
